// File: rtl/ahblite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahblite_cmd_master
//  Description : AHB-Lite initiator. Converts a valid/ready command stream of
//                single reads/writes into SINGLE NONSEQ transfers with
//                overlapped address/data phases, and returns in-order
//                responses through a two-entry response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahblite_cmd_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011,
   parameter int         RSP_DEPTH = 2
) (
   input  logic        HCLK,
   input  logic        HRESET,
   // command stream
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   // response stream
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   // AHB-Lite master
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      ERR1 = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Address slot: either a real bus transfer (ap_bus) or a locally rejected
   // command (ap_rej) waiting for its turn to report an error in order.
   // HADDR/HWRITE/HSIZE/ap_wdata hold the bus command, and also serve as the
   // held command while an ERROR response is being completed.
   logic        ap_bus;
   logic        ap_rej;
   logic [31:0] ap_wdata;
   logic        held_valid;

   // Data slot
   logic        dp_bus;
   logic        dp_rej;
   logic        dp_write;

   // Response FIFO and credit counter
   logic [32:0] fifo_mem [RSP_DEPTH];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  fifo_cnt;
   logic [1:0]  inflight;

   logic        cmd_bad;
   logic        accept;
   logic        pop;
   logic        push;
   logic        push_err;
   logic [31:0] push_rdata;
   logic        err_start;
   logic        err_done;
   logic        dp_done;
   logic        dp_free;
   logic        ap_bus_adv;
   logic        ap_rej_adv;
   logic        ap_to_held;
   logic        ap_free;

   assign HTRANS    = ap_bus ? 2'b10 : 2'b00;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

   // Illegal size or misaligned address: accepted, but answered locally
   assign cmd_bad = (cmd_size == 2'd3) ||
                    ((cmd_size == 2'd1) && cmd_addr[0]) ||
                    ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00));

   assign err_start  = (state == RUN) && dp_bus && HRESP && !HREADY;
   assign err_done   = (state == ERR1) && HREADY;
   assign dp_done    = dp_rej || (dp_bus && HREADY);
   assign dp_free    = (!dp_bus && !dp_rej) || dp_done;
   assign ap_bus_adv = ap_bus && HREADY;
   assign ap_rej_adv = ap_rej && dp_free;
   assign ap_to_held = ap_bus && err_start;
   assign ap_free    = (!ap_bus && !ap_rej) || ap_bus_adv || ap_rej_adv;

   assign cmd_ready = !held_valid && ap_free && (state != ERR1) &&
                      (inflight < 2'(RSP_DEPTH));
   assign accept    = cmd_valid && cmd_ready;

   assign rsp_valid = (fifo_cnt != 2'd0);
   assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr][31:0] : 32'h0;
   assign rsp_err   = rsp_valid && fifo_mem[rd_ptr][32];
   assign pop       = rsp_valid && rsp_ready;

   assign push       = dp_done;
   assign push_err   = dp_rej || (state == ERR1) || HRESP;
   assign push_rdata = (push_err || dp_write) ? 32'h0 : HRDATA;

   // FSM state register
   always_ff @(posedge HCLK) begin
      if (HRESET) state <= RUN;
      else        state <= state_nxt;
   end

   // FSM next state: enter ERR1 on the first ERROR cycle, leave on its second
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (err_start) state_nxt = ERR1;
         ERR1:    if (HREADY)    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Address slot: load on accept, reissue held command, park on error
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ap_bus     <= 1'b0;
         ap_rej     <= 1'b0;
         held_valid <= 1'b0;
         HADDR      <= 32'h0;
         HWRITE     <= 1'b0;
         HSIZE      <= 3'b000;
         ap_wdata   <= 32'h0;
      end else if (accept) begin
         ap_bus <= !cmd_bad;
         ap_rej <= cmd_bad;
         if (!cmd_bad) begin
            HADDR    <= cmd_addr;
            HWRITE   <= cmd_write;
            HSIZE    <= {1'b0, cmd_size};
            ap_wdata <= cmd_wdata;
         end
      end else if (err_done && held_valid) begin
         ap_bus     <= 1'b1;
         held_valid <= 1'b0;
      end else if (ap_to_held) begin
         ap_bus     <= 1'b0;
         held_valid <= 1'b1;
      end else begin
         if (ap_bus_adv) ap_bus <= 1'b0;
         if (ap_rej_adv) ap_rej <= 1'b0;
      end
   end

   // Data slot: follows the address slot, retires on completion
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_bus   <= 1'b0;
         dp_rej   <= 1'b0;
         dp_write <= 1'b0;
         HWDATA   <= 32'h0;
      end else if (ap_bus_adv) begin
         dp_bus   <= 1'b1;
         dp_rej   <= 1'b0;
         dp_write <= HWRITE;
         HWDATA   <= HWRITE ? ap_wdata : 32'h0;
      end else if (ap_rej_adv) begin
         dp_bus   <= 1'b0;
         dp_rej   <= 1'b1;
         dp_write <= 1'b0;
      end else if (dp_done) begin
         dp_bus   <= 1'b0;
         dp_rej   <= 1'b0;
      end
   end

   // Response FIFO; credits guarantee a free entry whenever a push occurs
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {push_err, push_rdata};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // Commands in flight: counted from accept until their response is popped
   always_ff @(posedge HCLK) begin
      if (HRESET) inflight <= 2'd0;
      else        inflight <= inflight + {1'b0, accept} - {1'b0, pop};
   end

endmodule
`default_nettype wire
